// File: rtl/helen_onchip_mem_dp_if.sv
// One Avalon-MM slave port of the dual-port on-chip RAM.
interface helen_onchip_mem_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/helen_onchip_mem_dp.sv
// Parametrised dual-port on-chip RAM with two Avalon-MM slave ports,
// byte-lane writes, 1- or 2-cycle read latency and optional zero-clear sweep.
module helen_onchip_mem_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int DEPTH          = 4096,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  reset_req,
  helen_onchip_mem_dp_if.slave  s1,
  helen_onchip_mem_dp_if.slave  s2,
  output logic                  init_done
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {RESET_ST, CLEAR, READY} state_t;

  state_t                state;
  logic [IW-1:0]         clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ce;
  logic                  go;
  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [NB-1:0]         be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [IW-1:0]         idx   [2];
  logic [DATA_WIDTH-1:0] rval  [2];
  logic [DATA_WIDTH-1:0] rdata [2];
  logic [1:0]            cs, rd, wr, in_rng, acc_rd, we, rv;

  assign ce = clken & ~reset_req;
  assign go = ce & reset_n & (state == READY);

  assign addr[0]  = s1.address;
  assign addr[1]  = s2.address;
  assign be[0]    = s1.byteenable;
  assign be[1]    = s2.byteenable;
  assign wdata[0] = s1.writedata;
  assign wdata[1] = s2.writedata;
  assign cs       = {s2.chipselect, s1.chipselect};
  assign rd       = {s2.read, s1.read};
  assign wr       = {s2.write, s1.write};

  assign s1.waitrequest   = ~go;
  assign s2.waitrequest   = ~go;
  assign s1.readdata      = rdata[0];
  assign s2.readdata      = rdata[1];
  assign s1.readdatavalid = rv[0];
  assign s2.readdatavalid = rv[1];
  assign init_done        = (state == READY);

  always_comb begin
    in_rng = '0;
    acc_rd = '0;
    we     = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      in_rng[p] = ({1'b0, addr[p]} < DEPTH_A);
      idx[p]    = addr[p][IW-1:0];
      rval[p]   = in_rng[p] ? mem[idx[p]] : '0;
      acc_rd[p] = go & cs[p] & rd[p] & ~wr[p];
    end
    // s1 owns the whole word when both ports write the same address
    we[0] = go & cs[0] & wr[0] & in_rng[0];
    we[1] = go & cs[1] & wr[1] & in_rng[1] & ~(we[0] & (idx[0] == idx[1]));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= RESET_ST;
      clr_cnt <= '0;
    end else if (ce) begin
      case (state)
        RESET_ST: begin
          clr_cnt <= '0;
          if (CLEAR_ON_RESET != 0) state <= CLEAR;
          else                     state <= READY;
        end
        CLEAR: begin
          if (clr_cnt == IW'(DEPTH - 1)) state <= READY;
          else                           clr_cnt <= clr_cnt + 1'b1;
        end
        READY:   state <= READY;
        default: state <= RESET_ST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ce && reset_n) begin
      if (state == CLEAR) mem[clr_cnt] <= '0;
      for (int unsigned p = 0; p < 2; p++) begin
        if (we[p]) begin
          for (int unsigned b = 0; b < NB; b++) begin
            if (be[p][b]) mem[idx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
          end
        end
      end
    end
  end

  // Pipeline stages hold while ce=0; only the valid pulse is dropped so a
  // response already presented is not repeated during the freeze.
  if (READ_LATENCY == 2) begin : g_rl2
    logic [1:0]            v1;
    logic [DATA_WIDTH-1:0] d1 [2];

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v1 <= '0;
        rv <= '0;
        for (int unsigned p = 0; p < 2; p++) begin
          d1[p]    <= '0;
          rdata[p] <= '0;
        end
      end else if (!ce) begin
        rv <= '0;
      end else begin
        for (int unsigned p = 0; p < 2; p++) begin
          v1[p] <= acc_rd[p];
          if (acc_rd[p]) d1[p] <= rval[p];
          rv[p] <= v1[p];
          if (v1[p]) rdata[p] <= d1[p];
        end
      end
    end
  end else begin : g_rl1
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        rv <= '0;
        for (int unsigned p = 0; p < 2; p++) rdata[p] <= '0;
      end else if (!ce) begin
        rv <= '0;
      end else begin
        for (int unsigned p = 0; p < 2; p++) begin
          rv[p] <= acc_rd[p];
          if (acc_rd[p]) rdata[p] <= rval[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_helen_onchip_mem_dp.sv
// Directed bench: instance A (DEPTH=3000, latency 1, no clear) and
// instance B (DEPTH=16, latency 2, clear sweep).
module tb_helen_onchip_mem_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, clken_a, rreq_a, init_a;
  logic rst_b, clken_b, rreq_b, init_b;

  helen_onchip_mem_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) a1 ();
  helen_onchip_mem_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) a2 ();
  helen_onchip_mem_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4))  b1 ();
  helen_onchip_mem_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4))  b2 ();

  helen_onchip_mem_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(3000), .READ_LATENCY(1), .CLEAR_ON_RESET(0)
  ) u_a (
    .clk(clk), .reset_n(rst_a), .clken(clken_a), .reset_req(rreq_a),
    .s1(a1), .s2(a2), .init_done(init_a)
  );

  helen_onchip_mem_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) u_b (
    .clk(clk), .reset_n(rst_b), .clken(clken_b), .reset_req(rreq_b),
    .s1(b1), .s2(b2), .init_done(init_b)
  );

  typedef struct packed {
    logic        cs, rd, wr;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } op_t;

  typedef struct packed {
    op_t         p1, p2;
    logic        ev1;
    logic [31:0] ed1;
    logic        ev2;
    logic [31:0] ed2;
  } vec_a_t;

  typedef struct packed {
    logic        ce;
    op_t         op;
    logic        ev;
    logic [31:0] ed;
    logic        ew;
  } vec_b_t;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] h1 = '0, h2 = '0, hb = '0;
  vec_a_t ta[$];
  vec_b_t tb_q[$];

  function automatic op_t opw(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    return '{1'b1, 1'b0, 1'b1, a, be, d};
  endfunction
  function automatic op_t opr(input logic [11:0] a);
    return '{1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0};
  endfunction
  function automatic op_t oprw(input logic [11:0] a, input logic [31:0] d);
    return '{1'b1, 1'b1, 1'b1, a, 4'hF, d};
  endfunction
  function automatic op_t op_nop();
    return '{1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0};
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, i, act, exp);
    end
  endtask

  task automatic set_a(input op_t o1, input op_t o2);
    a1.chipselect = o1.cs; a1.read = o1.rd; a1.write = o1.wr;
    a1.address = o1.addr; a1.byteenable = o1.be; a1.writedata = o1.wd;
    a2.chipselect = o2.cs; a2.read = o2.rd; a2.write = o2.wr;
    a2.address = o2.addr; a2.byteenable = o2.be; a2.writedata = o2.wd;
  endtask

  task automatic apply_a(input vec_a_t v, input int i);
    set_a(v.p1, v.p2);
    @(posedge clk); #1;
    chk("a_s1_valid", i, {31'd0, a1.readdatavalid}, {31'd0, v.ev1});
    if (v.ev1) h1 = v.ed1;
    chk("a_s1_rdata", i, a1.readdata, h1);
    chk("a_s2_valid", i, {31'd0, a2.readdatavalid}, {31'd0, v.ev2});
    if (v.ev2) h2 = v.ed2;
    chk("a_s2_rdata", i, a2.readdata, h2);
  endtask

  task automatic apply_b(input vec_b_t v, input int i);
    clken_b = v.ce;
    b1.chipselect = v.op.cs; b1.read = v.op.rd; b1.write = v.op.wr;
    b1.address = v.op.addr[3:0]; b1.byteenable = v.op.be; b1.writedata = v.op.wd;
    @(posedge clk); #1;
    chk("b_valid", i, {31'd0, b1.readdatavalid}, {31'd0, v.ev});
    if (v.ev) hb = v.ed;
    chk("b_rdata", i, b1.readdata, hb);
    chk("b_wait", i, {31'd0, b1.waitrequest}, {31'd0, v.ew});
  endtask

  // Counts edges after reset release during which init_done stays low.
  task automatic count_init(input bit use_b, output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if ((use_b ? init_b : init_a) === 1'b1) return;
      n++;
      chk("init_wait", n, {31'd0, use_b ? b1.waitrequest : a1.waitrequest}, 32'd1);
    end
    chk("init_timeout", n, {31'd0, use_b ? init_b : init_a}, 32'd1);
  endtask

  initial begin
    int n;
    rst_a = 1'b0; clken_a = 1'b1; rreq_a = 1'b0;
    rst_b = 1'b0; clken_b = 1'b1; rreq_b = 1'b0;
    set_a(op_nop(), op_nop());
    b1.chipselect = 1'b0; b1.read = 1'b0; b1.write = 1'b0;
    b1.address = '0; b1.byteenable = '0; b1.writedata = '0;
    b2.chipselect = 1'b0; b2.read = 1'b0; b2.write = 1'b0;
    b2.address = '0; b2.byteenable = '0; b2.writedata = '0;

    ta.push_back('{opw(12'h005, 4'hF, 32'hDEADBEEF), op_nop(), 1'b0, 32'h0, 1'b0, 32'h0});
    ta.push_back('{opr(12'h005), op_nop(), 1'b1, 32'hDEADBEEF, 1'b0, 32'h0});
    ta.push_back('{op_nop(), op_nop(), 1'b0, 32'h0, 1'b0, 32'h0});
    ta.push_back('{opw(12'h006, 4'hF, 32'h11223344), op_nop(), 1'b0, 32'h0, 1'b0, 32'h0});
    ta.push_back('{opw(12'h006, 4'h5, 32'hAABBCCDD), op_nop(), 1'b0, 32'h0, 1'b0, 32'h0});
    ta.push_back('{opr(12'h006), op_nop(), 1'b1, 32'h11BB33DD, 1'b0, 32'h0});
    ta.push_back('{opw(12'h010, 4'hF, 32'hAAAAAAAA), opw(12'h010, 4'hF, 32'h55555555), 1'b0, 32'h0, 1'b0, 32'h0});
    ta.push_back('{opr(12'h010), opr(12'h005), 1'b1, 32'hAAAAAAAA, 1'b1, 32'hDEADBEEF});
    ta.push_back('{opw(12'h010, 4'hF, 32'h00000001), opr(12'h010), 1'b0, 32'h0, 1'b1, 32'hAAAAAAAA});
    ta.push_back('{op_nop(), opr(12'h010), 1'b0, 32'h0, 1'b1, 32'h00000001});
    ta.push_back('{op_nop(), opw(12'h011, 4'hF, 32'h01020304), 1'b0, 32'h0, 1'b0, 32'h0});
    ta.push_back('{opr(12'h011), opw(12'h011, 4'hF, 32'hCAFEF00D), 1'b1, 32'h01020304, 1'b0, 32'h0});
    ta.push_back('{opr(12'h011), op_nop(), 1'b1, 32'hCAFEF00D, 1'b0, 32'h0});
    ta.push_back('{opw(12'h012, 4'hF, 32'h00000000), op_nop(), 1'b0, 32'h0, 1'b0, 32'h0});
    ta.push_back('{opw(12'h012, 4'h1, 32'h000000EE), opw(12'h012, 4'hE, 32'h12345600), 1'b0, 32'h0, 1'b0, 32'h0});
    ta.push_back('{op_nop(), opr(12'h012), 1'b0, 32'h0, 1'b1, 32'h000000EE});
    ta.push_back('{opw(12'h001, 4'hF, 32'h0BADCAFE), op_nop(), 1'b0, 32'h0, 1'b0, 32'h0});
    ta.push_back('{opw(12'hBB9, 4'hF, 32'hFFFFFFFF), opr(12'hBB8), 1'b0, 32'h0, 1'b1, 32'h0});
    ta.push_back('{opr(12'h001), opr(12'hBB9), 1'b1, 32'h0BADCAFE, 1'b1, 32'h0});
    ta.push_back('{oprw(12'h020, 32'h00000077), op_nop(), 1'b0, 32'h0, 1'b0, 32'h0});
    ta.push_back('{opr(12'h020), op_nop(), 1'b1, 32'h00000077, 1'b0, 32'h0});
    ta.push_back('{op_t'{1'b0, 1'b1, 1'b0, 12'h005, 4'h0, 32'h0}, op_nop(), 1'b0, 32'h0, 1'b0, 32'h0});
    ta.push_back('{op_nop(), op_t'{1'b0, 1'b0, 1'b1, 12'h010, 4'hF, 32'hFFFFFFFF}, 1'b0, 32'h0, 1'b0, 32'h0});
    ta.push_back('{op_nop(), opr(12'h010), 1'b0, 32'h0, 1'b1, 32'h00000001});

    // Reset values on both instances
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_rdata", 0, a1.readdata, 32'h0);
    chk("rst_a_valid", 0, {31'd0, a1.readdatavalid}, 32'd0);
    chk("rst_a_wait", 0, {30'd0, a2.waitrequest, a1.waitrequest}, 32'd3);
    chk("rst_a_init", 0, {31'd0, init_a}, 32'd0);
    chk("rst_b_rdata", 0, b1.readdata, 32'h0);
    chk("rst_b_wait", 0, {31'd0, b1.waitrequest}, 32'd1);
    chk("rst_b_init", 0, {31'd0, init_b}, 32'd0);

    rst_a = 1'b1;
    count_init(1'b0, n);
    chk("a_ready_delay", 0, n, 32'd0);
    foreach (ta[i]) apply_a(ta[i], i);

    // reset_req blocks a write, then normal traffic resumes
    rreq_a = 1'b1;
    apply_a('{opw(12'h005, 4'hF, 32'h0), op_nop(), 1'b0, 32'h0, 1'b0, 32'h0}, 100);
    chk("rreq_wait", 100, {31'd0, a1.waitrequest}, 32'd1);
    rreq_a = 1'b0;
    apply_a('{opr(12'h005), op_nop(), 1'b1, 32'hDEADBEEF, 1'b0, 32'h0}, 101);

    // Instance B: initial sweep, preload, reset, sweep, readback
    rst_b = 1'b1;
    count_init(1'b1, n);
    chk("b_sweep0", 0, n, 32'd16);
    apply_b('{1'b1, opw(12'h3, 4'hF, 32'h12345678), 1'b0, 32'h0, 1'b0}, 0);
    apply_b('{1'b1, opr(12'h3), 1'b0, 32'h0, 1'b0}, 1);
    apply_b('{1'b1, op_nop(), 1'b1, 32'h12345678, 1'b0}, 2);
    apply_b('{1'b1, op_nop(), 1'b0, 32'h0, 1'b0}, 3);
    rst_b = 1'b0;
    @(posedge clk); #1;
    hb = '0;
    chk("b_rst_rdata", 0, b1.readdata, 32'h0);
    chk("b_rst_init", 0, {31'd0, init_b}, 32'd0);
    rst_b = 1'b1;
    count_init(1'b1, n);
    chk("b_sweep1", 0, n, 32'd16);
    apply_b('{1'b1, opr(12'h3), 1'b0, 32'h0, 1'b0}, 4);
    apply_b('{1'b1, op_nop(), 1'b1, 32'h0, 1'b0}, 5);

    // Reset interrupting a sweep restarts the full sweep
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("b_mid_init", 0, {31'd0, init_b}, 32'd0);
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    count_init(1'b1, n);
    chk("b_sweep2", 0, n, 32'd16);

    // Pipelined reads with a three-cycle clock-enable freeze
    for (int k = 0; k < 4; k++)
      tb_q.push_back('{1'b1, opw(12'(k), 4'hF, 32'hA0000000 + 32'(k)), 1'b0, 32'h0, 1'b0});
    tb_q.push_back('{1'b1, opr(12'h0), 1'b0, 32'h0, 1'b0});
    tb_q.push_back('{1'b1, opr(12'h1), 1'b1, 32'hA0000000, 1'b0});
    tb_q.push_back('{1'b0, opr(12'h2), 1'b0, 32'h0, 1'b1});
    tb_q.push_back('{1'b0, opr(12'h2), 1'b0, 32'h0, 1'b1});
    tb_q.push_back('{1'b0, opr(12'h2), 1'b0, 32'h0, 1'b1});
    tb_q.push_back('{1'b1, opr(12'h2), 1'b1, 32'hA0000001, 1'b0});
    tb_q.push_back('{1'b1, opr(12'h3), 1'b1, 32'hA0000002, 1'b0});
    tb_q.push_back('{1'b1, op_nop(), 1'b1, 32'hA0000003, 1'b0});
    tb_q.push_back('{1'b1, op_nop(), 1'b0, 32'h0, 1'b0});
    foreach (tb_q[i]) apply_b(tb_q[i], 10 + i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/helen_onchip_mem_dp.md
Name: helen_onchip_mem_dp

Overview:
Parametrised dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2). It succeeds the fixed 4096x32 single-port on-chip memory. Adds configurable width, depth and read latency, explicit read/readdatavalid/waitrequest handshakes, defined collision rules, and an optional post-reset zero-clear sweep. It sits on the system interconnect as program/data memory, with s2 serving a second master such as DMA.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 12, word-address width per port
DEPTH, 4096, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values are 1 or 2
CLEAR_ON_RESET, 0, 1 = zero every word after reset before accepting traffic

Ports:
clk  in  1  system clock; the only clock in the block
reset_n  in  1  synchronous active-low reset, sampled on rising clk
clken  in  1  global clock enable
reset_req  in  1  reset-pending request; gates clocking like ~clken
s1_address  in  ADDR_WIDTH  port 1 word address
s1_byteenable  in  DATA_WIDTH/8  port 1 byte lane enables for writes
s1_chipselect  in  1  port 1 select
s1_read  in  1  port 1 read request
s1_write  in  1  port 1 write request
s1_writedata  in  DATA_WIDTH  port 1 write data
s1_readdata  out  DATA_WIDTH  port 1 read data
s1_readdatavalid  out  1  port 1 read data valid, one-cycle pulse
s1_waitrequest  out  1  port 1 stall
s2_*  same set as s1_*, port 2
init_done  out  1  high once the block is in READY

Behaviour:
- Define ce = clken & ~reset_req. While ce=0, memory, read pipeline and FSM hold state, and both waitrequests are forced to 1.
- Reset: while reset_n=0 at a clk edge, the following apply.
  - readdata=0, readdatavalid=0, waitrequest=1 on both ports, init_done=0.
  - Read pipeline is flushed.
  - FSM enters RESET_ST.
  - Memory contents are not altered by reset itself.
- FSM states and transitions:
  - RESET_ST -> CLEAR if CLEAR_ON_RESET=1, otherwise -> READY, on the first edge with reset_n=1 and ce=1.
  - CLEAR: an internal counter runs 0..DEPTH-1, writing all-zero with all byte lanes enabled, one word per ce cycle. Both waitrequests stay 1. After word DEPTH-1 is written, next state is READY.
  - READY: waitrequest = ~ce on each port; init_done=1.
  - reset_n=0 in any state returns to RESET_ST. A sweep interrupted by reset restarts at 0.
- Accept rule: a port accepts a command on an edge where chipselect=1 and (read|write)=1 and waitrequest=0. There is no back-pressure beyond waitrequest.
- read and write asserted together on one port: the write executes and no read response is produced.
- Writes take effect at the accepting edge. Only lanes with byteenable[i]=1 are updated, where lane i is bits 8i+7..8i.
- Reads:
  - readdatavalid pulses high exactly READ_LATENCY cycles after the accepting edge (ce=1 throughout).
  - readdata holds its last value when readdatavalid=0.
  - Back-to-back reads are allowed on every cycle, giving one response per cycle, in order.
- Out-of-range address (address >= DEPTH): writes are dropped; reads return 0 with a normal readdatavalid.
- Read-during-write, same port, same address, same edge: cannot occur because write wins.
- Mixed-port collisions on the same address at the same edge:
  - s2 read while s1 writes returns the old data; s1 read while s2 writes returns the old data.
  - Both ports writing: s1 wins the whole word and s2's write is discarded entirely, including lanes only s2 enabled.
- Pipeline freeze: if ce drops with reads in flight, responses are delayed by the number of ce=0 cycles and are never lost or duplicated.
- Memory is an inferred behavioural array with registered address, plus an optional second output register when READ_LATENCY=2.

Test Plan:
1. Write/read: defaults, CLEAR_ON_RESET=0. s1 write addr 0x005 data 0xDEADBEEF be=0xF, then s1 read addr 0x005 -> readdatavalid exactly 1 cycle later, readdata=0xDEADBEEF.
2. Byte enables: write 0x11223344 be=0xF, then write 0xAABBCCDD be=0x5 to the same address, then read -> 0x11BB33DD.
3. Clear sweep: CLEAR_ON_RESET=1, DEPTH=16, preload addr 3 = 0x12345678. Pulse reset_n low 1 cycle -> waitrequest high and init_done=0 for exactly 16 ce cycles after release, then read addr 3 -> 0x00000000. Reasserting reset mid-sweep at count 7 -> a full 16-cycle sweep follows.
4. Collision: same edge, s1 write 0xAAAAAAAA and s2 write 0x55555555 to addr 0x010 -> readback 0xAAAAAAAA. Same edge, s1 write 0x1 and s2 read addr 0x010 -> s2 sees 0xAAAAAAAA.
5. Pipelined reads with freeze: READ_LATENCY=2, s1 reads addrs 0,1,2,3 on consecutive cycles, with clken low for 3 cycles after the 2nd read -> 4 valid pulses in order, the last 3 delayed by 3 cycles, and waitrequest=1 during the clken-low cycles.
6. Range and read/write: DEPTH=3000, read addr 3000 -> readdata 0 with valid. Write addr 3001 is dropped and addr 3001 mod 3000 is unchanged. read+write asserted together -> write performed, no valid pulse.
